rv32_m_ext: RTL and testbench

External RV32M multiply/divide unit: the responder side of the EX-stage external M interface. It accepts a one-cycle start pulse with operands and funct3, computes iteratively, and returns the result with a one-cycle acknowledge. The EX stage holds the pipeline stalled until the acknowledge.

---
 rtl/arvi_m_pkg.sv | 44 ++++
 rtl/rv32_m_ext_iter_core.sv | 75 +++++++
 rtl/rv32_m_ext.sv | 165 ++++++++++++++++
 tb/tb_rv32_m_ext.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_m_pkg.sv
// -----------------------------------------------------------------------------
// arvi_m_pkg
// Shared types and constants for the external RV32M multiply/divide unit.
//   - XLEN      : operand/result width, taken from the `XLEN define (default 32)
//   - CNT_W     : iteration counter width (must hold 0..XLEN)
//   - m_op_e    : funct3 encodings of the M extension
//   - m_state_e : responder FSM states
// Optional feature macro used by the unit: ARVI_M_FAST_MUL_EN.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package arvi_m_pkg;

  localparam int XLEN  = `XLEN;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } m_state_e;

  localparam logic [XLEN-1:0] M_DIV_ZERO_Q   = '1;
  localparam logic [XLEN-1:0] M_OVF_DIVIDEND = 32'h8000_0000;

  // Every divide/remainder encoding has funct3[2] set.
  function automatic logic op_is_div(input m_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/rv32_m_ext_iter_core.sv
// -----------------------------------------------------------------------------
// m_iter_core
// Unsigned iterative datapath shared by multiply and divide. One step per
// enabled clock edge.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : capture operand magnitudes (a_i, b_i) for a new operation
//   step_i       : perform one radix-2 step
//   mode_div_i   : 0 = shift-add multiply, 1 = restoring shift-subtract divide
//   a_i, b_i     : unsigned magnitudes (multiplicand/dividend, multiplier/divisor)
//   acc_o        : 2*XLEN accumulator (product, or {remainder, quotient})
//   acc_next_o   : accumulator value after the step currently being taken
//   quot_o/rem_o : quotient / remainder views of the accumulator
// -----------------------------------------------------------------------------
module m_iter_core
  import arvi_m_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              mode_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [2*XLEN-1:0] acc_next_o,
  output logic [XLEN-1:0]   quot_o,
  output logic [XLEN-1:0]   rem_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   lo, hi;
  logic [XLEN:0]     sum, rs, diff;

  assign lo = acc_q[XLEN-1:0];
  assign hi = acc_q[2*XLEN-1:XLEN];

  // Multiply: the multiplier sits in the low half and is consumed LSB first
  // while the partial product shifts in from the top.
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);

  // Divide: {remainder, quotient} shift left together; the dividend drains
  // out of the low half into the remainder. Because the running remainder is
  // always below the divisor, diff[XLEN] is a clean borrow flag.
  assign rs   = {hi, lo[XLEN-1]};
  assign diff = rs - {1'b0, opnd_q};

  always_comb begin
    acc_d = acc_q;
    if (mode_div_i) begin
      if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      else             acc_d = {rs[XLEN-1:0],   lo[XLEN-2:0], 1'b0};
    end else begin
      acc_d = {sum, lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load_i) begin
      acc_q  <= {{XLEN{1'b0}}, (mode_div_i ? a_i : b_i)};
      opnd_q <= mode_div_i ? b_i : a_i;
    end else if (step_i) begin
      acc_q  <= acc_d;
    end
  end

  assign acc_o      = acc_q;
  assign acc_next_o = acc_d;
  assign quot_o     = acc_q[XLEN-1:0];
  assign rem_o      = acc_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/rv32_m_ext.sv
// -----------------------------------------------------------------------------
// rv32_m_ext
// External RV32M multiply/divide responder. Accepts a one-cycle start pulse,
// computes iteratively (32 steps) and returns the result with a one-cycle ack.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-low reset
//   i_en   : start pulse, only honoured in IDLE
//   i_rs1  : operand A (dividend / multiplicand)
//   i_rs2  : operand B (divisor / multiplier)
//   i_f3   : funct3 (MUL..REMU)
//   o_res  : result, updated on entry to DONE and held until the next one
//   o_ack  : completion strobe, one cycle
// Optional macro ARVI_M_FAST_MUL_EN: single-cycle 33x33 multiplier for all
// multiplies (ack one cycle after capture). Undefined: iterative multiply.
// -----------------------------------------------------------------------------
module rv32_m_ext
  import arvi_m_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_res,
  output logic            o_ack
);

  m_state_e          state_q;
  logic [CNT_W-1:0]  cnt_q;
  m_op_e             op_q;
  logic              neg_q, sign_a_q, fast_q;
  logic [XLEN-1:0]   fast_res_q, res_q;

  m_op_e             op_in;
  logic              signed_a, signed_b, sa, sb, is_div, div_zero, ovf, fast_hit;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res_c, res_sel;
  logic [XLEN-1:0]   quot_u, rem_u, quot_s, rem_s;
  logic [2*XLEN-1:0] acc, acc_next, prod_s;
  logic              core_load, core_step, core_mode;

  // ---------------- capture-side decode (used at the start edge) ----------
  assign op_in    = m_op_e'(i_f3);
  assign signed_a = op_in inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM};
  assign signed_b = op_in inside {M_MUL, M_MULH, M_DIV, M_REM};
  assign sa       = signed_a & i_rs1[XLEN-1];
  assign sb       = signed_b & i_rs2[XLEN-1];
  assign mag_a    = sa ? (~i_rs1 + 1'b1) : i_rs1;
  assign mag_b    = sb ? (~i_rs2 + 1'b1) : i_rs2;
  assign is_div   = op_is_div(op_in);
  assign div_zero = is_div && (i_rs2 == '0);
  assign ovf      = (op_in == M_DIV || op_in == M_REM) &&
                    (i_rs1 == M_OVF_DIVIDEND) && (i_rs2 == '1);

`ifdef ARVI_M_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN+1:0] fast_prod;
  assign fm_a      = {sa, i_rs1};
  assign fm_b      = {sb, i_rs2};
  assign fast_prod = fm_a * fm_b;
  assign fast_hit  = div_zero | ovf | !is_div;
`else
  assign fast_hit  = div_zero | ovf;
`endif

  // Result for operations that bypass the iterative datapath.
  always_comb begin
    fast_res_c = '0;
    if (div_zero) begin
      fast_res_c = (op_in == M_DIV || op_in == M_DIVU) ? M_DIV_ZERO_Q : i_rs1;
    end else if (ovf) begin
      fast_res_c = (op_in == M_DIV) ? M_OVF_DIVIDEND : '0;
`ifdef ARVI_M_FAST_MUL_EN
    end else if (!is_div) begin
      fast_res_c = (op_in == M_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif
    end
  end

  // ---------------- iterative datapath ------------------------------------
  assign core_load = (state_q == IDLE) && i_en;
  assign core_step = (state_q == CALC) && !fast_q;
  // Mode must be valid both on the load edge (from inputs) and while stepping.
  assign core_mode = (state_q == IDLE) ? is_div : op_q[2];

  m_iter_core u_core (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .load_i     (core_load),
    .step_i     (core_step),
    .mode_div_i (core_mode),
    .a_i        (mag_a),
    .b_i        (mag_b),
    .acc_o      (acc),
    .acc_next_o (acc_next),
    .quot_o     (quot_u),
    .rem_o      (rem_u)
  );

  // The result is written on the final step edge, so it is formed from the
  // accumulator value that step produces rather than the registered one.
  assign prod_s = neg_q    ? (~acc_next + 1'b1) : acc_next;
  assign quot_s = neg_q    ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
  assign rem_s  = sign_a_q ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];

  always_comb begin
    res_sel = '0;
    case (op_q)
      M_MUL:                       res_sel = prod_s[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU:   res_sel = prod_s[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:               res_sel = quot_s;
      default:                     res_sel = rem_s;
    endcase
  end

  // ---------------- control FSM --------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= M_MUL;
      neg_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      res_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_en) begin
            op_q       <= op_in;
            neg_q      <= sa ^ sb;
            sign_a_q   <= sa;
            fast_q     <= fast_hit;
            fast_res_q <= fast_res_c;
            cnt_q      <= '0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (fast_q) begin
            res_q   <= fast_res_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
              res_q   <= res_sel;
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_res = res_q;
  assign o_ack = (state_q == DONE);

  // Debug views of the raw datapath are not consumed by the control logic.
  logic unused_core;
  assign unused_core = ^{acc, quot_u, rem_u};

endmodule

// File: tb/tb_rv32_m_ext.sv
module tb_rv32_m_ext;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en  = 1'b0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic [2:0]  i_f3  = '0;
  logic [31:0] o_res;
  logic        o_ack;

  int total = 0;
  int bad   = 0;

`ifdef ARVI_M_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif

  rv32_m_ext dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .i_rs1 (i_rs1),
    .i_rs2 (i_rs2),
    .i_f3  (i_f3),
    .o_res (o_res),
    .o_ack (o_ack)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (plain arithmetic) ---------------------
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  // ---------------- stimulus driver (no checking) --------------------------
  // Starts at a negedge, ends at a negedge. lat = cycles after the capture
  // edge until ack is seen (-1 if none within budget).
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat,
                       output logic ack_next, output logic [31:0] res_hold);
    i_rs1 = a; i_rs2 = b; i_f3 = f3; i_en = 1'b1;
    @(posedge i_clk); #1;
    i_en  = 1'b0;
    i_rs1 = $urandom; i_rs2 = $urandom; i_f3 = 3'($urandom);
    lat = -1;
    res = 'x;
    for (int n = 1; n <= 100; n++) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_ack) begin lat = n; res = o_res; break; end
    end
    @(posedge i_clk); @(negedge i_clk);
    ack_next = o_ack;
    res_hold = o_res;
    $display("op f3=%0d a=%08h b=%08h res=%08h lat=%0d", f3, a, b, res, lat);
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    i_en  = 1'b1;
    #2;
    total++; if (o_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", o_ack); end
    total++; if (o_res !== 32'h0) begin bad++; $display("FAIL reset_res: got %08h want 00000000", o_res); end
    repeat (3) @(negedge i_clk);
    total++; if (o_ack !== 1'b0) begin bad++; $display("FAIL reset_ack_held: got %b want 0", o_ack); end
    i_en  = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
  endtask

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [5:0]  lat;
  } vec_t;

  task automatic test_directed();
    vec_t        v [12];
    logic [31:0] res, hold;
    int          lat;
    logic        ackn;
    v = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 6'(MUL_LAT)},
      '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 6'(MUL_LAT)},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'(MUL_LAT)},
      '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 6'(MUL_LAT)},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 6'd32},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 6'd32},
      '{3'd5, 32'd100,        32'd7,         32'd14,        6'd32},
      '{3'd7, 32'd100,        32'd7,         32'd2,         6'd32},
      '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 6'd1},
      '{3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, 6'd1},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 6'd1},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         6'd1}
    };
    for (int i = 0; i < 12; i++) begin
      do_op(v[i].f3, v[i].a, v[i].b, res, lat, ackn, hold);
      total++; if (res !== v[i].exp) begin bad++; $display("FAIL directed_res[%0d]: got %08h want %08h", i, res, v[i].exp); end
      total++; if (lat !== int'(v[i].lat)) begin bad++; $display("FAIL directed_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      total++; if (ackn !== 1'b0) begin bad++; $display("FAIL directed_ack_width[%0d]: ack still %b want 0", i, ackn); end
      total++; if (hold !== v[i].exp) begin bad++; $display("FAIL directed_hold[%0d]: got %08h want %08h", i, hold, v[i].exp); end
    end
  endtask

  // Back-to-back random operations, each started in the cycle after the
  // previous one returned to IDLE.
  task automatic test_random();
    logic [31:0] a, b, res, hold, exp;
    logic [2:0]  f3;
    int          lat, elat;
    logic        ackn;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      exp  = ref_res(f3, a, b);
      elat = ref_lat(f3, a, b);
      do_op(f3, a, b, res, lat, ackn, hold);
      total++; if (res !== exp) begin bad++; $display("FAIL random_res[%0d] f3=%0d a=%08h b=%08h: got %08h want %08h", i, f3, a, b, res, exp); end
      total++; if (lat !== elat) begin bad++; $display("FAIL random_lat[%0d]: got %0d want %0d", i, lat, elat); end
      total++; if (ackn !== 1'b0) begin bad++; $display("FAIL random_ack_width[%0d]: ack still %b want 0", i, ackn); end
      total++; if (hold !== exp) begin bad++; $display("FAIL random_hold[%0d]: got %08h want %08h", i, hold, exp); end
    end
  endtask

  task automatic test_repulse();
    int          acks, first_lat;
    logic [31:0] first_res;
    acks = 0; first_lat = -1; first_res = 'x;
    i_rs1 = 32'd100; i_rs2 = 32'd7; i_f3 = 3'd4; i_en = 1'b1;
    @(posedge i_clk); #1;
    i_en = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge i_clk); @(negedge i_clk);
      if (o_ack) begin
        acks++;
        if (first_lat < 0) begin first_lat = n; first_res = o_res; end
      end
      if (n == 5) begin
        i_rs1 = 32'd1000; i_rs2 = 32'd3; i_f3 = 3'd5; i_en = 1'b1;
      end else begin
        i_en = 1'b0;
      end
    end
    $display("op repulse DIV 100/7 res=%08h lat=%0d acks=%0d", first_res, first_lat, acks);
    total++; if (acks !== 1) begin bad++; $display("FAIL repulse_acks: got %0d want 1", acks); end
    total++; if (first_res !== 32'd14) begin bad++; $display("FAIL repulse_res: got %08h want 0000000e", first_res); end
    total++; if (first_lat !== 32) begin bad++; $display("FAIL repulse_lat: got %0d want 32", first_lat); end
  endtask

  task automatic test_async_reset();
    int          acks;
    logic [31:0] res, hold;
    int          lat;
    logic        ackn;
    // o_res currently holds 14 from the previous test.
    i_rs1 = $urandom; i_rs2 = 32'd9; i_f3 = 3'd5; i_en = 1'b1;
    @(posedge i_clk); #1;
    i_en = 1'b0;
    repeat (10) @(negedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    total++; if (o_ack !== 1'b0) begin bad++; $display("FAIL async_reset_ack: got %b want 0", o_ack); end
    total++; if (o_res !== 32'h0) begin bad++; $display("FAIL async_reset_res: got %08h want 00000000", o_res); end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    acks = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      if (o_ack) acks++;
    end
    $display("op async_reset acks_after_release=%0d", acks);
    total++; if (acks !== 0) begin bad++; $display("FAIL async_reset_no_ack: got %0d acks want 0", acks); end
    do_op(3'd0, 32'd3, 32'd4, res, lat, ackn, hold);
    total++; if (res !== 32'd12) begin bad++; $display("FAIL post_reset_mul: got %08h want 0000000c", res); end
    total++; if (lat !== MUL_LAT) begin bad++; $display("FAIL post_reset_lat: got %0d want %0d", lat, MUL_LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_repulse();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
